// File: rtl/lorenz_scm_pkg.sv
// Shared definitions for the Lorenz/Chen chaotic-system engine.
// Contents: controller state enum, system-select encoding, and the
// elaboration-time helpers that turn rational coefficients into signed
// fixed-point constants for a given word width and fractional bit count.
package lorenz_scm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC_X,
    ST_CALC_Y,
    ST_CALC_Z,
    ST_OUT,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_LORENZ = 1'b0,
    MODE_CHEN   = 1'b1
  } mode_t;

  // floor(num/den * 2^frac), clamped to the signed range of a width-bit word
  // so that coefficients too large for a narrow integer part pin at the rail.
  function automatic longint fxp_ratio(input longint num, input longint den,
                                       input int frac, input int width);
    longint v;
    longint lim;
    lim = (longint'(1) <<< (width - 1)) - 1;
    v   = (num <<< frac) / den;
    if (v > lim) v = lim;
    if (v < -lim - 1) v = -lim - 1;
    return v;
  endfunction

  function automatic longint fxp_int(input longint value, input int frac, input int width);
    return fxp_ratio(value, 1, frac, width);
  endfunction

endpackage

// File: rtl/lorenz_scm_engine_fxp_mul_sat.sv
// fxp_mul_sat: signed fixed-point multiplier with saturation.
// Ports:
//   a, b : signed Width-bit operands in the same Q format
//   p    : full-precision product shifted right by Frac (floor), clipped
//          to the signed Width-bit range
//   ovf  : high when the clip was applied
module fxp_mul_sat #(
  parameter int Width = 32,
  parameter int Frac  = 21
) (
  input  logic signed [Width-1:0] a,
  input  logic signed [Width-1:0] b,
  output logic signed [Width-1:0] p,
  output logic                    ovf
);

  logic signed [2*Width-1:0] a_ext;
  logic signed [2*Width-1:0] b_ext;
  logic signed [2*Width-1:0] full;
  logic signed [2*Width-1:0] shifted;
  logic        [Width:0]     upper;

  assign a_ext   = {{Width{a[Width-1]}}, a};
  assign b_ext   = {{Width{b[Width-1]}}, b};
  assign full    = a_ext * b_ext;
  assign shifted = full >>> Frac;

  // The result fits only when every bit from the new sign position upward
  // is a copy of the sign.
  assign upper = shifted[2*Width-1:Width-1];
  assign ovf   = !((&upper) || !(|upper));

  assign p = !ovf ? shifted[Width-1:0]
           : shifted[2*Width-1] ? {1'b1, {(Width-1){1'b0}}}
           : {1'b0, {(Width-1){1'b1}}};

endmodule

// File: rtl/lorenz_scm_engine.sv
// lorenz_scm_engine: iterates the Lorenz or Chen system with a semi-implicit
// Euler step in signed fixed point, one state variable per clock, and hands
// each new state vector to a consumer through a valid/ready handshake.
// Ports:
//   clk_i, rst_i         : clock (rising edge), asynchronous active-low reset
//   start_i              : run request (held high for the duration of a run)
//   mode_i               : 0 Lorenz, 1 Chen (latched at run start)
//   h_i                  : step size (latched at run start)
//   n_iter_i             : iterations per run, 0 = free-running (latched)
//   ready_i              : consumer accepts the presented sample
//   xn_o, yn_o, zn_o     : current state vector
//   valid_o, busy_o      : sample presented / run in progress
//   done_o, ovf_o        : run complete / sticky saturation seen this run
module lorenz_scm_engine
  import lorenz_scm_pkg::*;
#(
  parameter int Width = 32,
  parameter int Frac  = 21,
  parameter logic signed [Width-1:0] X0 = Width'(fxp_int(1, Frac, Width)),
  parameter logic signed [Width-1:0] Y0 = Width'(fxp_int(1, Frac, Width)),
  parameter logic signed [Width-1:0] Z0 = Width'(fxp_int(1, Frac, Width))
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic signed [Width-1:0] h_i,
  input  logic        [31:0]      n_iter_i,
  input  logic                    ready_i,
  output logic signed [Width-1:0] xn_o,
  output logic signed [Width-1:0] yn_o,
  output logic signed [Width-1:0] zn_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o
);

  localparam logic signed [Width-1:0] K_SIGMA = Width'(fxp_int(10, Frac, Width));
  localparam logic signed [Width-1:0] K_RHO   = Width'(fxp_int(28, Frac, Width));
  localparam logic signed [Width-1:0] K_BETA  = Width'(fxp_ratio(8, 3, Frac, Width));
  localparam logic signed [Width-1:0] K_A     = Width'(fxp_int(35, Frac, Width));
  localparam logic signed [Width-1:0] K_B     = Width'(fxp_int(3, Frac, Width));
  localparam logic signed [Width-1:0] K_C     = Width'(fxp_int(28, Frac, Width));
  localparam logic signed [Width-1:0] K_CMA   = Width'(fxp_int(28 - 35, Frac, Width));

  state_t state;
  state_t state_nxt;

  logic signed [Width-1:0] x_q, y_q, z_q, h_q;
  mode_t                   mode_q;
  logic        [31:0]      n_iter_q, cnt_q;
  logic                    ovf_q, stop_q;

  logic signed [Width-1:0] m0_a, m0_b, m0_p, m1_a, m1_b, m1_p;
  logic signed [Width-1:0] m2_a, m2_b, m2_p, m3_p;
  logic                    m0_ovf, m1_ovf, m2_ovf, m3_ovf;
  logic signed [Width-1:0] diff, tmp, u, upd_base, upd;
  logic                    d_ovf, u_ovf0, u_ovf1, upd_ovf, step_ovf;

  function automatic logic signed [Width-1:0] sat_add(
    input  logic signed [Width-1:0] a,
    input  logic signed [Width-1:0] b,
    input  logic                    sub,
    output logic                    sat
  );
    logic signed [Width:0] s;
    if (sub) s = {a[Width-1], a} - {b[Width-1], b};
    else     s = {a[Width-1], a} + {b[Width-1], b};
    sat = (s[Width] != s[Width-1]);
    if (!sat)         return s[Width-1:0];
    else if (s[Width]) return {1'b1, {(Width-1){1'b0}}};
    else              return {1'b0, {(Width-1){1'b1}}};
  endfunction

  fxp_mul_sat #(.Width(Width), .Frac(Frac)) u_mul0 (.a(m0_a), .b(m0_b), .p(m0_p), .ovf(m0_ovf));
  fxp_mul_sat #(.Width(Width), .Frac(Frac)) u_mul1 (.a(m1_a), .b(m1_b), .p(m1_p), .ovf(m1_ovf));
  fxp_mul_sat #(.Width(Width), .Frac(Frac)) u_mul2 (.a(m2_a), .b(m2_b), .p(m2_p), .ovf(m2_ovf));
  fxp_mul_sat #(.Width(Width), .Frac(Frac)) u_mul3 (.a(h_q),  .b(u),    .p(m3_p), .ovf(m3_ovf));

  // Operands of the bracketed derivative term for the variable being updated.
  // Idle multipliers see zero so they can never raise a spurious overflow.
  // x_q already holds x' during CALC_Y/CALC_Z, and y_q holds y' in CALC_Z.
  always_comb begin
    m0_a  = '0;
    m0_b  = '0;
    m1_a  = '0;
    m1_b  = '0;
    m2_a  = '0;
    m2_b  = '0;
    diff  = '0;
    d_ovf = 1'b0;
    case (state)
      ST_CALC_X: begin
        diff = sat_add(y_q, x_q, 1'b1, d_ovf);
        m0_a = diff;
        m0_b = (mode_q == MODE_CHEN) ? K_A : K_SIGMA;
      end
      ST_CALC_Y: begin
        if (mode_q == MODE_CHEN) begin
          m0_a = x_q;
          m0_b = K_CMA;
          m1_a = x_q;
          m1_b = z_q;
          m2_a = y_q;
          m2_b = K_C;
        end else begin
          diff = sat_add(K_RHO, z_q, 1'b1, d_ovf);
          m0_a = x_q;
          m0_b = diff;
        end
      end
      ST_CALC_Z: begin
        m0_a = x_q;
        m0_b = y_q;
        m1_a = z_q;
        m1_b = (mode_q == MODE_CHEN) ? K_B : K_BETA;
      end
      default: ;
    endcase
  end

  // Combine the products into the bracketed term; it is multiplied by h next.
  always_comb begin
    u      = '0;
    tmp    = '0;
    u_ovf0 = 1'b0;
    u_ovf1 = 1'b0;
    case (state)
      ST_CALC_X: u = m0_p;
      ST_CALC_Y: begin
        if (mode_q == MODE_CHEN) begin
          tmp = sat_add(m0_p, m1_p, 1'b1, u_ovf0);
          u   = sat_add(tmp, m2_p, 1'b0, u_ovf1);
        end else begin
          u = sat_add(m0_p, y_q, 1'b1, u_ovf0);
        end
      end
      ST_CALC_Z: u = sat_add(m0_p, m1_p, 1'b1, u_ovf0);
      default: ;
    endcase
  end

  // Euler accumulation v + h*u for the variable selected by the state.
  always_comb begin
    upd_ovf  = 1'b0;
    upd_base = x_q;
    case (state)
      ST_CALC_Y: upd_base = y_q;
      ST_CALC_Z: upd_base = z_q;
      default:   upd_base = x_q;
    endcase
    upd      = sat_add(upd_base, m3_p, 1'b0, upd_ovf);
    step_ovf = d_ovf | u_ovf0 | u_ovf1 | upd_ovf | m0_ovf | m1_ovf | m2_ovf | m3_ovf;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode. A run ends at a handshake either because
  // the requested count is reached or because start_i was withdrawn.
  always_comb begin
    state_nxt = state;
    valid_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_LOAD;
      ST_LOAD:   begin busy_o = 1'b1; state_nxt = ST_CALC_X; end
      ST_CALC_X: begin busy_o = 1'b1; state_nxt = ST_CALC_Y; end
      ST_CALC_Y: begin busy_o = 1'b1; state_nxt = ST_CALC_Z; end
      ST_CALC_Z: begin busy_o = 1'b1; state_nxt = ST_OUT; end
      ST_OUT: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        if (ready_i) begin
          if (n_iter_q != 32'd0 && (cnt_q + 32'd1) == n_iter_q) state_nxt = ST_DONE;
          else if (stop_q || !start_i)                         state_nxt = ST_IDLE;
          else                                                 state_nxt = ST_CALC_X;
        end
      end
      ST_DONE: begin
        done_o = 1'b1;
        if (!start_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: run configuration, state vector, iteration counter,
  // sticky overflow and the pending-stop request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      h_q      <= '0;
      mode_q   <= MODE_LORENZ;
      n_iter_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          x_q      <= X0;
          y_q      <= Y0;
          z_q      <= Z0;
          h_q      <= h_i;
          mode_q   <= mode_t'(mode_i);
          n_iter_q <= n_iter_i;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
        end
        ST_CALC_X: begin x_q <= upd; ovf_q <= ovf_q | step_ovf; end
        ST_CALC_Y: begin y_q <= upd; ovf_q <= ovf_q | step_ovf; end
        ST_CALC_Z: begin z_q <= upd; ovf_q <= ovf_q | step_ovf; end
        ST_OUT:    if (ready_i) cnt_q <= cnt_q + 32'd1;
        default: ;
      endcase
      if (state == ST_IDLE)         stop_q <= 1'b0;
      else if (busy_o && !start_i)  stop_q <= 1'b1;
    end
  end

  assign xn_o  = x_q;
  assign yn_o  = y_q;
  assign zn_o  = z_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_lorenz_scm_engine.sv
// Self-checking bench for lorenz_scm_engine (Width 32, Frac 21).
// A longint model of the semi-implicit Euler step predicts every sample;
// a compare process checks the DUT whenever it presents a sample, and
// directed sequences pin latency, handshake spacing, backpressure, stop,
// saturation and reset behaviour.
module tb_lorenz_scm_engine;

  localparam int     FRAC = 21;
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;
  localparam longint ONE  = 64'sd1 <<< FRAC;
  localparam longint SIG  = 10 * ONE;
  localparam longint RHO  = 28 * ONE;
  localparam longint BETA = (8 * ONE) / 3;
  localparam longint CA   = 35 * ONE;
  localparam longint CB   = 3 * ONE;
  localparam longint CC   = 28 * ONE;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic signed [31:0] h = '0;
  logic        [31:0] n_iter = '0;
  logic               ready = 1'b0;
  logic signed [31:0] xn, yn, zn;
  logic               valid, busy, done, ovf;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int edges;
  int hs0;

  longint mx, my, mz, lx, ly, lz, model_h;
  bit     movf, model_mode, model_armed, sat_seen;

  lorenz_scm_engine dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .h_i(h),
    .n_iter_i(n_iter), .ready_i(ready), .xn_o(xn), .yn_o(yn), .zn_o(zn),
    .valid_o(valid), .busy_o(busy), .done_o(done), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic longint satv(input longint v);
    if (v > MAXV) begin sat_seen = 1'b1; return MAXV; end
    if (v < MINV) begin sat_seen = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic longint fm(input longint a, input longint b);
    return satv((a * b) >>> FRAC);
  endfunction

  // One Euler step of the selected system; saturations make ovf sticky.
  task automatic modelStep();
    longint nx, ny, nz;
    sat_seen = 1'b0;
    if (!model_mode) begin
      nx = satv(mx + fm(model_h, fm(satv(my - mx), SIG)));
      ny = satv(my + fm(model_h, satv(fm(nx, satv(RHO - mz)) - my)));
      nz = satv(mz + fm(model_h, satv(fm(nx, ny) - fm(BETA, mz))));
    end else begin
      nx = satv(mx + fm(model_h, fm(satv(my - mx), CA)));
      ny = satv(my + fm(model_h, satv(satv(fm(CC - CA, nx) - fm(nx, mz)) + fm(CC, my))));
      nz = satv(mz + fm(model_h, satv(fm(nx, ny) - fm(CB, mz))));
    end
    mx = nx; my = ny; mz = nz;
    movf = movf | sat_seen;
  endtask

  // Count handshakes and advance the model past each accepted sample.
  always @(posedge clk) begin
    if (rst_n && valid && ready) begin
      hs_count++;
      if (model_armed) begin
        lx = mx; ly = my; lz = mz;
        modelStep();
      end
    end
  end

  // Every presented sample must match the model.
  always @(negedge clk) begin
    if (rst_n && model_armed && valid) begin
      checkOutput("sample_x", longint'(xn), mx);
      checkOutput("sample_y", longint'(yn), my);
      checkOutput("sample_z", longint'(zn), mz);
      checkOutput("sample_ovf", longint'(ovf), longint'(movf));
      checkOutput("sample_busy", longint'(busy), 1);
      checkOutput("sample_done", longint'(done), 0);
    end
  end

  // Return to IDLE, program the run, prime the model with its first sample.
  task automatic applyStimulus(input bit m, input logic [31:0] hv, input logic [31:0] n);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mode = m; h = hv; n_iter = n;
    model_mode = m;
    model_h = longint'($signed(hv));
    mx = ONE; my = ONE; mz = ONE; movf = 1'b0;
    modelStep();
    model_armed = 1'b1;
    start = 1'b1;
  endtask

  task automatic waitValid(input string name, input int limit, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt = 0;
    while (!seen && cnt < limit) begin
      @(posedge clk); #1;
      cnt++;
      if (valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("[TB] FAIL %s: valid_o not seen within %0d edges", name, limit);
    end
  endtask

  task automatic driveHandshakes(input int target, input int limit);
    int cyc;
    cyc = 0;
    while (hs_count < target && cyc < limit) begin
      @(negedge clk);
      ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    checkOutput("handshakes_reached", longint'(hs_count >= target), 1);
  endtask

  task automatic checkHeld(input string name);
    checkOutput({name, "_x"}, longint'(xn), lx);
    checkOutput({name, "_y"}, longint'(yn), ly);
    checkOutput({name, "_z"}, longint'(zn), lz);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_x", longint'(xn), 0);
    checkOutput("reset_valid", longint'(valid), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_ovf", longint'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lorenz, h = 2^-10, three iterations with ready held high.
    ready = 1'b1;
    applyStimulus(1'b0, 32'h0000_0800, 32'd3);
    checkOutput("model_pin_x", mx, 64'sh0020_0000);
    checkOutput("model_pin_y", my, 64'sh0020_D000);
    checkOutput("model_pin_z", mz, 64'sh001F_F2DE);
    hs0 = hs_count;
    waitValid("first_valid", 20, edges);
    checkOutput("first_valid_latency", edges, 5);
    checkOutput("first_x", longint'(xn), 64'sh0020_0000);
    checkOutput("first_y", longint'(yn), 64'sh0020_D000);
    checkOutput("first_z", longint'(zn), 64'sh001F_F2DE);
    for (int k = 0; k < 2; k++) begin
      waitValid("next_valid", 20, edges);
      checkOutput("handshake_spacing", edges, 4);
    end
    @(posedge clk); #1;
    checkOutput("done_after_n", longint'(done), 1);
    checkOutput("busy_after_n", longint'(busy), 0);
    checkOutput("valid_after_n", longint'(valid), 0);
    checkOutput("handshakes_n3", hs_count - hs0, 3);
    checkHeld("done_held");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_stays", longint'(done), 1);
    checkOutput("handshakes_n3_final", hs_count - hs0, 3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_done", longint'(done), 0);
    checkOutput("idle_busy", longint'(busy), 0);
    checkHeld("idle_held");

    // Chen with maximal step: saturation and sticky overflow.
    ready = 1'b1;
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd0);
    waitValid("sat_valid", 20, edges);
    checkOutput("sat_x", longint'(xn), 64'sh0020_0000);
    checkOutput("sat_y", longint'(yn), 64'sh7FFF_FFFF);
    checkOutput("sat_z", longint'(zn), 64'sh7FFF_FFFF);
    checkOutput("sat_ovf", longint'(ovf), 1);
    driveHandshakes(hs_count + 5, 200);
    @(negedge clk);
    ready = 1'b1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("sat_stop_valid", longint'(valid), 0);
    checkOutput("sat_stop_busy", longint'(busy), 0);
    checkOutput("ovf_sticky_idle", longint'(ovf), 1);

    // Free-running Lorenz: ovf cleared by LOAD, config changes ignored,
    // backpressure, random ready.
    ready = 1'b0;
    applyStimulus(1'b0, 32'h0000_2000, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("ovf_cleared_by_load", longint'(ovf), 0);
    checkOutput("busy_in_run", longint'(busy), 1);
    mode = 1'b1; h = 32'h7FFF_FFFF; n_iter = 32'd1;
    waitValid("bp_valid", 20, edges);
    hs0 = hs_count;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", longint'(valid), 1);
    end
    checkOutput("bp_no_handshake", hs_count - hs0, 0);
    driveHandshakes(hs0 + 15, 400);

    // Drop start during CALC_Y: one more handshake, then IDLE without done.
    @(negedge clk);
    ready = 1'b1;
    waitValid("stop_valid", 20, edges);
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    hs0 = hs_count;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("stop_one_more", hs_count - hs0, 1);
    checkOutput("stop_valid", longint'(valid), 0);
    checkOutput("stop_busy", longint'(busy), 0);
    checkOutput("stop_done", longint'(done), 0);
    checkHeld("stop_held");

    // Asynchronous reset while presenting a sample.
    ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0400, 32'd0);
    waitValid("rst_valid", 20, edges);
    @(negedge clk);
    #2;
    model_armed = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("async_rst_x", longint'(xn), 0);
    checkOutput("async_rst_y", longint'(yn), 0);
    checkOutput("async_rst_z", longint'(zn), 0);
    checkOutput("async_rst_valid", longint'(valid), 0);
    checkOutput("async_rst_busy", longint'(busy), 0);
    checkOutput("async_rst_done", longint'(done), 0);
    checkOutput("async_rst_ovf", longint'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post_rst_valid", longint'(valid), 0);
    checkOutput("post_rst_busy", longint'(busy), 0);

    // Randomized counted runs.
    for (int r = 0; r < 4; r++) begin
      int n;
      bit m;
      logic [31:0] hv;
      m  = 1'($urandom_range(0, 1));
      hv = 32'($urandom_range(1, 32'h8000));
      n  = $urandom_range(1, 5);
      applyStimulus(m, hv, 32'(n));
      hs0 = hs_count;
      repeat (3) @(posedge clk);
      #1;
      mode = ~m; h = 32'($urandom); n_iter = 32'($urandom_range(1, 9));
      driveHandshakes(hs0 + n, 300);
      repeat (8) @(negedge clk);
      checkOutput("rand_handshakes", hs_count - hs0, n);
      checkOutput("rand_done", longint'(done), 1);
      checkOutput("rand_busy", longint'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lorenz_scm_engine.md
LORENZ_SCM_ENGINE -- requirements
Module: lorenz_scm_engine

Interface
REQ-001 SHALL have parameter Width, default 32, total signed fixed-point word width.
REQ-002 SHALL have parameter Frac, default 21, fractional bits; legal range 1 to Width-4.
REQ-003 SHALL have parameters X0, Y0, Z0, default 1.0 in Q(Width-Frac).Frac (0x00200000), initial conditions.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, run request; sampled only in IDLE.
REQ-007 SHALL have port mode_i, input, 1, system select: 0 = Lorenz (sigma 10, rho 28, beta 8/3), 1 = Chen (a 35, b 3, c 28).
REQ-008 SHALL have port h_i, input, Width, step size, same Q format as the outputs.
REQ-009 SHALL have port n_iter_i, input, 32, iteration count; 0 means free-running.
REQ-010 SHALL have port ready_i, input, 1, consumer accepts the current sample.
REQ-011 SHALL have ports xn_o, yn_o, zn_o, output, Width each, current state vector.
REQ-012 SHALL have ports valid_o, busy_o, done_o, ovf_o, output, 1 each: sample valid, run in progress, run complete, sticky saturation flag.

Function
REQ-013 SHALL implement states IDLE, LOAD, CALC_X, CALC_Y, CALC_Z, OUT, DONE, advancing one state per clock except in OUT.
REQ-014 SHALL go from IDLE to LOAD when start_i=1; LOAD SHALL load X0/Y0/Z0, clear the iteration counter and ovf_o, and latch mode_i, h_i and n_iter_i for the whole run.
REQ-015 SHALL apply the semi-implicit update in Lorenz mode: CALC_X x'=x+h*sigma*(y-x); CALC_Y y'=y+h*(x'*(rho-z)-y); CALC_Z z'=z+h*(x'*y'-beta*z).
REQ-016 SHALL apply the semi-implicit update in Chen mode: x'=x+h*a*(y-x); y'=y+h*((c-a)*x'-x'*z+c*y); z'=z+h*(x'*y'-b*z).
REQ-017 SHALL form every product at 2*Width bits, arithmetic-shift it right by Frac (truncation toward minus infinity), and saturate it to the Width signed range.
REQ-018 SHALL saturate every sum rather than wrap; any saturation event SHALL set ovf_o until the next LOAD or reset.
REQ-019 SHALL derive coefficients from Frac at elaboration; beta = floor(8/3*2^Frac).
REQ-020 SHALL hold valid_o=1 for the whole time it is in OUT, with xn_o/yn_o/zn_o stable there.
REQ-021 SHALL stay in OUT with outputs held while ready_i=0 (backpressure).
REQ-022 SHALL, on valid_o & ready_i, increment the counter, then go to DONE if the counter equals n_iter_i (n_iter_i nonzero), else to CALC_X.
REQ-023 SHALL have valid_o first high 5 rising edges after the edge sampling start_i; each later sample SHALL be valid 4 edges after the preceding handshake edge.
REQ-024 SHALL, in DONE, assert done_o and hold the final outputs; it SHALL return to IDLE when start_i=0.
REQ-025 SHALL keep busy_o=1 in LOAD through OUT and 0 in IDLE and DONE.
REQ-026 SHALL, on start_i=0 during a run, finish the current iteration, and on the next OUT handshake go to IDLE with outputs held and done_o=0.
REQ-027 SHALL ignore changes to mode_i, h_i and n_iter_i during a run.
REQ-028 SHALL let the 32-bit counter wrap in free-running mode without affecting operation.

Reset
REQ-029 SHALL, on rst_i=0, immediately force state IDLE, xn_o/yn_o/zn_o=0, valid_o, busy_o, done_o and ovf_o=0, and counter=0, regardless of the current state.
REQ-030 SHALL, on rst_i deassertion, wait in IDLE for start_i; a reset during OUT SHALL drop valid_o in the same cycle.

Structure
REQ-031 SHALL place the state enum, mode encoding and coefficient constant functions in shared package lorenz_scm_pkg.
REQ-032 SHALL use sub-module fxp_mul_sat (signed multiply, shift by Frac, saturate, overflow flag), instantiated per product.

Verification
REQ-033 SHALL cover: reset held low mid-run -> all outputs 0 within the same cycle; IDLE after release.
REQ-034 SHALL cover: Width 32, Frac 21, mode 0, h_i 0x00000800 (2^-10), start -> valid_o 5 edges later with xn_o=0x00200000 and yn_o=0x0020D000.
REQ-035 SHALL cover: n_iter_i=3, ready_i=1 -> exactly 3 valid handshakes 4 edges apart, then done_o=1 and busy_o=0.
REQ-036 SHALL cover: ready_i=0 for 10 cycles in OUT -> valid_o and outputs stable, counter unchanged.
REQ-037 SHALL cover: h_i=0x7FFFFFFF, mode 1 -> outputs clip to 0x7FFFFFFF or 0x80000000 and ovf_o=1 until the next start.
REQ-038 SHALL cover: start_i dropped during CALC_Y, free-running -> one more handshake, then IDLE with done_o=0.
